// File: rtl/mesh_sort_pkg.sv
// Shared types and sizing helpers for the shearsort mesh sequencer.
// Widths are derived from the mesh side length so every file agrees on them.
package mesh_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLE,
    ST_DONE
  } state_e;

  // log2(side) column phases sandwiched between log2(side)+1 row phases
  function automatic int num_phases(input int sqrt_n);
    return 2 * $clog2(sqrt_n) + 1;
  endfunction

  function automatic int step_width(input int sqrt_n);
    return $clog2(sqrt_n);
  endfunction

  function automatic int phase_width(input int sqrt_n);
    return $clog2(num_phases(sqrt_n));
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MODULUS up counter with enable; wrap_o flags the enabled cycle
// that returns the count to zero so counters can be chained.
module mod_counter #(
  parameter int MODULUS = 4,
  parameter int W       = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;

  assign wrap_o  = en_i && (count_q == W'(MODULUS - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mesh_sort_ctrl.sv
// Shearsort sequencer: start/done handshake plus the per-cycle
// compare-exchange controls broadcast to every PE of the mesh.
module mesh_sort_ctrl
  import mesh_sort_pkg::*;
#(
  parameter int SQRT_N     = 4,
  // Derived values; leave at their defaults.
  parameter int LOG_SQRT_N = step_width(SQRT_N),
  parameter int NUM_PHASES = num_phases(SQRT_N),
  parameter int PHASE_W    = phase_width(SQRT_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  descending,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  cx_valid,
  output logic                  col_phase,
  output logic                  odd_pair,
  output logic                  snake,
  output logic                  dir,
  output logic [PHASE_W-1:0]    phase_idx,
  output logic [LOG_SQRT_N-1:0] step_idx
);

  state_e state_q;
  logic   busy_q, done_q, dir_q;
  logic   run, step_en, step_wrap, phase_wrap;

  assign run     = (state_q == ST_RUN);
  assign step_en = run && !stall;

  mod_counter #(
    .MODULUS(SQRT_N),
    .W      (LOG_SQRT_N)
  ) u_step_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (step_en),
    .count_o(step_idx),
    .wrap_o (step_wrap)
  );

  mod_counter #(
    .MODULUS(NUM_PHASES),
    .W      (PHASE_W)
  ) u_phase_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (step_wrap),
    .count_o(phase_idx),
    .wrap_o (phase_wrap)
  );

  // Both counters are back at zero when the last phase wraps, so IDLE needs no clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            dir_q   <= descending;
          end
        end
        ST_RUN: begin
          if (phase_wrap) begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dir       = dir_q;
  assign cx_valid  = step_en;
  assign col_phase = phase_idx[0];
  assign odd_pair  = step_idx[0];
  assign snake     = run && !phase_idx[0];

endmodule

// File: tb/tb_mesh_sort_ctrl.sv
// Scoreboard bench for mesh_sort_ctrl: per-cycle control expectations are queued
// at each start and popped every cycle; a behavioural mesh checks the sorted keys.
module tb_mesh_sort_ctrl;

  localparam int N4  = 4;
  localparam int NP4 = 5;

  typedef struct packed {
    logic       bsy;
    logic       dn;
    logic       cx;
    logic       col;
    logic       odd;
    logic       snk;
    logic [2:0] ph;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, descending = 1'b0, stall = 1'b0;
  logic busy, done, cx_valid, col_phase, odd_pair, snake, dir;
  logic [2:0] phase_idx;
  logic [1:0] step_idx;

  logic start8 = 1'b0, desc8 = 1'b0, stall8 = 1'b0;
  logic busy8, done8, cx8, col8, odd8, snake8, dir8;
  logic [2:0] phase8, step8;

  int checks = 0;
  int errors = 0;
  exp_t expQ[$];
  exp_t monExp, monObs;
  logic monOn = 1'b0;
  int cyc = 0, cxCnt = 0, doneCnt = 0, doneCyc = -1;
  int mem[2][64];

  always #5 clk = ~clk;

  mesh_sort_ctrl #(.SQRT_N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .descending(descending), .stall(stall),
    .busy(busy), .done(done), .cx_valid(cx_valid), .col_phase(col_phase),
    .odd_pair(odd_pair), .snake(snake), .dir(dir),
    .phase_idx(phase_idx), .step_idx(step_idx)
  );

  mesh_sort_ctrl #(.SQRT_N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .descending(desc8), .stall(stall8),
    .busy(busy8), .done(done8), .cx_valid(cx8), .col_phase(col8),
    .odd_pair(odd8), .snake(snake8), .dir(dir8),
    .phase_idx(phase8), .step_idx(step8)
  );

  // One odd-even transposition step across every row or column of mesh id.
  task automatic mesh_step(input int id, input int n, input logic colp, input logic oddp,
                           input logic snk, input logic dr);
    int a, b, ia, ib;
    logic asc;
    for (int l = 0; l < n; l++) begin
      for (int i = (oddp ? 1 : 0); i + 1 < n; i += 2) begin
        if (colp) begin
          ia = i * n + l; ib = (i + 1) * n + l; asc = 1'b1;
        end else begin
          ia = l * n + i; ib = l * n + i + 1; asc = !(snk && (l % 2 == 1));
        end
        if (dr) asc = !asc;
        a = mem[id][ia];
        b = mem[id][ib];
        if (asc ? (a > b) : (a < b)) begin
          mem[id][ia] = b;
          mem[id][ib] = a;
        end
      end
    end
  endtask

  always @(negedge clk) if (cx_valid) mesh_step(0, 4, col_phase, odd_pair, snake, dir);
  always @(negedge clk) if (cx8) mesh_step(1, 8, col8, odd8, snake8, dir8);

  always @(negedge clk) begin
    if (monOn) begin
      cyc = cyc + 1;
      if (cx_valid) cxCnt = cxCnt + 1;
      if (done) begin
        doneCnt = doneCnt + 1;
        doneCyc = cyc;
      end
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        monObs = {busy, done, cx_valid, col_phase, odd_pair, snake, phase_idx, step_idx};
        checks = checks + 1;
        if (monObs !== monExp) begin
          errors = errors + 1;
          $display("[TB] FAIL seq cyc=%0d got=%b want=%b (bsy dn cx col odd snk ph st)",
                   cyc, monObs, monExp);
        end
      end
    end
  end

  // Expected per-cycle view of a full run, optionally with ns stalls at (sp, ss).
  task automatic push_seq(input int sp, input int ss, input int ns);
    exp_t e;
    for (int p = 0; p < NP4; p++) begin
      for (int s = 0; s < N4; s++) begin
        e = '0;
        e.bsy = 1'b1;
        e.col = 1'(p % 2);
        e.odd = 1'(s % 2);
        e.snk = (p % 2 == 0);
        e.ph  = 3'(p);
        e.st  = 2'(s);
        if (p == sp && s == ss) repeat (ns) expQ.push_back(e);
        e.cx = 1'b1;
        expQ.push_back(e);
      end
    end
    e = '0; e.bsy = 1'b1; expQ.push_back(e);
    e = '0; e.dn = 1'b1;  expQ.push_back(e);
    e = '0;               expQ.push_back(e);
  endtask

  // Call right after a posedge; returns 1 ns into the first RUN cycle.
  task automatic launch(input logic desc, input int sp, input int ss, input int ns);
    #1 start = 1'b1;
    descending = desc;
    @(posedge clk);
    #1 start = 1'b0;
    push_seq(sp, ss, ns);
    cyc = 0; cxCnt = 0; doneCnt = 0; doneCyc = -1;
  endtask

  task automatic wait_queue();
    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(posedge clk);
    checks = checks + 1;
    if (expQ.size() != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL queue_drain left=%0d want=0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({busy, done, cx_valid, col_phase, odd_pair, snake, dir, phase_idx, step_idx} !== '0) begin
      errors = errors + 1;
      $display("[TB] FAIL reset_outputs got=%b want=0",
               {busy, done, cx_valid, col_phase, odd_pair, snake, dir, phase_idx, step_idx});
    end
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if ({busy, cx_valid, phase_idx, step_idx} !== '0) begin
      errors = errors + 1;
      $display("[TB] FAIL idle_stall got=%b want=0", {busy, cx_valid, phase_idx, step_idx});
    end
    @(posedge clk);
    #1 stall = 1'b0;
  endtask

  task automatic check_mesh(input string name, input int id, input int n, input logic desc);
    int r, c, want;
    for (int k = 0; k < n * n; k++) begin
      r = k / n;
      c = (r % 2 == 1) ? n - 1 - k % n : k % n;
      want = desc ? n * n - 1 - k : k;
      checks = checks + 1;
      if (mem[id][r * n + c] != want) begin
        errors = errors + 1;
        $display("[TB] FAIL %s pos=%0d got=%0d want=%0d", name, k, mem[id][r * n + c], want);
      end
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 16; k++) mem[0][k] = k;
    @(posedge clk);
    launch(1'b1, -1, -1, 0);
    wait_queue();
    checks = checks + 1;
    if (cxCnt != 20) begin errors = errors + 1; $display("[TB] FAIL basic_cx got=%0d want=20", cxCnt); end
    checks = checks + 1;
    if (doneCyc != 22) begin errors = errors + 1; $display("[TB] FAIL basic_done got=%0d want=22", doneCyc); end
    checks = checks + 1;
    if (doneCnt != 1) begin errors = errors + 1; $display("[TB] FAIL basic_pulses got=%0d want=1", doneCnt); end
    checks = checks + 1;
    if (dir !== 1'b1) begin errors = errors + 1; $display("[TB] FAIL basic_dir got=%b want=1", dir); end
    check_mesh("mesh_desc", 0, 4, 1'b1);
  endtask

  task automatic test_stall();
    for (int k = 0; k < 16; k++) mem[0][k] = 15 - k;
    @(posedge clk);
    launch(1'b0, 2, 1, 3);
    repeat (9) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_queue();
    checks = checks + 1;
    if (doneCyc != 25) begin errors = errors + 1; $display("[TB] FAIL stall_done got=%0d want=25", doneCyc); end
    checks = checks + 1;
    if (cxCnt != 20) begin errors = errors + 1; $display("[TB] FAIL stall_cx got=%0d want=20", cxCnt); end
    check_mesh("mesh_asc_stall", 0, 4, 1'b0);
  endtask

  task automatic test_start_ignored();
    @(posedge clk);
    launch(1'b1, -1, -1, 0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    descending = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_queue();
    checks = checks + 1;
    if (doneCyc != 22) begin errors = errors + 1; $display("[TB] FAIL ignore_done got=%0d want=22", doneCyc); end
    checks = checks + 1;
    if (doneCnt != 1) begin errors = errors + 1; $display("[TB] FAIL ignore_pulses got=%0d want=1", doneCnt); end
    checks = checks + 1;
    if (dir !== 1'b1) begin errors = errors + 1; $display("[TB] FAIL ignore_dir got=%b want=1", dir); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    launch(1'b0, -1, -1, 0);
    for (int i = 0; i < 100 && doneCnt == 0; i++) @(posedge clk);
    checks = checks + 1;
    if (doneCyc != 22) begin errors = errors + 1; $display("[TB] FAIL b2b_first_done got=%0d want=22", doneCyc); end
    for (int k = 0; k < 16; k++) mem[0][k] = (k * 7) % 16;
    launch(1'b0, -1, -1, 0);
    wait_queue();
    checks = checks + 1;
    if (doneCyc != 22) begin errors = errors + 1; $display("[TB] FAIL b2b_second_done got=%0d want=22", doneCyc); end
    checks = checks + 1;
    if (cxCnt != 20) begin errors = errors + 1; $display("[TB] FAIL b2b_cx got=%0d want=20", cxCnt); end
    check_mesh("mesh_asc_b2b", 0, 4, 1'b0);
  endtask

  task automatic test_reset_midrun();
    @(posedge clk);
    launch(1'b1, -1, -1, 0);
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    checks = checks + 1;
    if (phase_idx !== 3'd3) begin errors = errors + 1; $display("[TB] FAIL midrun_phase got=%0d want=3", phase_idx); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({busy, done, cx_valid, col_phase, odd_pair, snake, dir, phase_idx, step_idx} !== '0) begin
      errors = errors + 1;
      $display("[TB] FAIL midrun_reset got=%b want=0",
               {busy, done, cx_valid, col_phase, odd_pair, snake, dir, phase_idx, step_idx});
    end
    repeat (30) @(posedge clk);
    checks = checks + 1;
    if (doneCnt != 0) begin errors = errors + 1; $display("[TB] FAIL midrun_no_done got=%0d want=0", doneCnt); end
    launch(1'b0, -1, -1, 0);
    wait_queue();
    checks = checks + 1;
    if (cxCnt != 20) begin errors = errors + 1; $display("[TB] FAIL rerun_cx got=%0d want=20", cxCnt); end
    checks = checks + 1;
    if (doneCyc != 22) begin errors = errors + 1; $display("[TB] FAIL rerun_done got=%0d want=22", doneCyc); end
  endtask

  task automatic test_sqrt8();
    int keys[$];
    int c8, d8, dc8, r, c;
    for (int k = 0; k < 64; k++) begin
      mem[1][k] = int'($urandom_range(0, 999));
      keys.push_back(mem[1][k]);
    end
    keys.sort();
    @(posedge clk);
    #1 start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    c8 = 0; d8 = -1; dc8 = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (cx8) c8++;
      if (done8) begin dc8++; d8 = n; end
    end
    checks = checks + 1;
    if (c8 != 56) begin errors = errors + 1; $display("[TB] FAIL n8_cx got=%0d want=56", c8); end
    checks = checks + 1;
    if (d8 != 58) begin errors = errors + 1; $display("[TB] FAIL n8_done got=%0d want=58", d8); end
    checks = checks + 1;
    if (dc8 != 1) begin errors = errors + 1; $display("[TB] FAIL n8_pulses got=%0d want=1", dc8); end
    checks = checks + 1;
    if ({busy8, phase8, step8} !== '0) begin
      errors = errors + 1;
      $display("[TB] FAIL n8_idle got=%b want=0", {busy8, phase8, step8});
    end
    for (int k = 0; k < 64; k++) begin
      r = k / 8;
      c = (r % 2 == 1) ? 7 - k % 8 : k % 8;
      checks = checks + 1;
      if (mem[1][r * 8 + c] != keys[k]) begin
        errors = errors + 1;
        $display("[TB] FAIL n8_mesh pos=%0d got=%0d want=%0d", k, mem[1][r * 8 + c], keys[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    monOn = 1'b1;
    test_basic();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_sqrt8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
